// File: rtl/twiddle_sequencer_pkg.sv
// Shared definitions for the twiddle sequencer slice.
//  - twiddle_t    : default-width signed twiddle word
//  - seq_state_t  : sequencer control states
//  - sat_neg()    : saturating two's-complement negation for a word of width w
package twiddle_sequencer_pkg;

  localparam int TW_W = 16;

  typedef logic signed [TW_W-1:0] twiddle_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Negates a sign-extended w-bit value (w <= 31). The only value whose
  // negation does not fit is -2^(w-1); it clamps to 2^(w-1)-1.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int unsigned      w);
    logic signed [31:0] hi;
    logic signed [31:0] n;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    n  = -x;
    return (n > hi) ? hi : n;
  endfunction

endpackage

// File: rtl/twiddle_sequencer_if.sv
// Config and twiddle-stream handshake bundle.
//  master : issues config (cfg_val/cfg_stage/cfg_inverse), consumes beats (tw_rdy)
//  slave  : the sequencer; answers cfg_rdy and drives tw_val/tw_real/tw_imag/tw_index/tw_last
interface twiddle_sequencer_if
  import twiddle_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH = 16,
  parameter int SIZE_FFT  = 8
);
  localparam int LOG2_N = $clog2(SIZE_FFT);
  localparam int SW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  logic                        cfg_val;
  logic                        cfg_rdy;
  logic [SW-1:0]               cfg_stage;
  logic                        cfg_inverse;
  logic                        tw_val;
  logic                        tw_rdy;
  logic signed [BIT_WIDTH-1:0] tw_real;
  logic signed [BIT_WIDTH-1:0] tw_imag;
  logic [LOG2_N-2:0]           tw_index;
  logic                        tw_last;

  modport master (
    output cfg_val, cfg_stage, cfg_inverse, tw_rdy,
    input  cfg_rdy, tw_val, tw_real, tw_imag, tw_index, tw_last
  );

  modport slave (
    input  cfg_val, cfg_stage, cfg_inverse, tw_rdy,
    output cfg_rdy, tw_val, tw_real, tw_imag, tw_index, tw_last
  );

endinterface

// File: rtl/twiddle_sequencer_index_calc.sv
// Combinational sine-table addressing for butterfly k of stage s.
//  k       : butterfly index, 0..N/2-1
//  s       : stage, already clamped to 0..LOG2_N-1
//  idx_sin : table address of sin(angle)
//  idx_cos : table address of cos(angle) = sin(angle + pi/2), wrapped mod N
module twiddle_index_calc
  import twiddle_sequencer_pkg::*;
#(
  parameter int SIZE_FFT = 8
) (
  input  logic [$clog2(SIZE_FFT)-2:0]                                  k,
  input  logic [(($clog2(SIZE_FFT) > 1) ? $clog2($clog2(SIZE_FFT)) : 1)-1:0] s,
  output logic [$clog2(SIZE_FFT)-1:0]                                  idx_sin,
  output logic [$clog2(SIZE_FFT)-1:0]                                  idx_cos
);
  localparam int LOG2_N = $clog2(SIZE_FFT);
  localparam int KW     = LOG2_N - 1;
  localparam int SW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  logic [KW-1:0] mask;
  logic [KW-1:0] m;
  logic [SW:0]   sh;

  // m*N >> (s+1) equals m << (LOG2_N-1-s) exactly, because m < 2^s.
  // For s = KW the shifted one falls off the top and the subtraction wraps
  // to all ones, which is the wanted full mask.
  always_comb begin
    mask    = (KW'(1) << s) - KW'(1);
    m       = k & mask;
    sh      = (SW+1)'(LOG2_N - 1) - {1'b0, s};
    idx_sin = {1'b0, m} << sh;
    idx_cos = idx_sin + LOG2_N'(SIZE_FFT / 4);
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Streaming twiddle source for a stage-serial radix-2 FFT.
//  clk, reset   : clock and synchronous active-high reset
//  sine_wave_in : full-period sine table, entry m = sin(2*pi*m/N); hold static while running
//  bus (slave)  : config handshake (cfg_val/cfg_rdy, cfg_stage, cfg_inverse) and the
//                 twiddle stream (tw_val/tw_rdy, tw_real, tw_imag, tw_index, tw_last)
// A config handshake starts a run of N/2 beats in butterfly order; the first beat is
// valid the cycle after the handshake and each accepted beat is replaced on the same edge.
module twiddle_sequencer
  import twiddle_sequencer_pkg::*;
#(
  parameter int BIT_WIDTH  = 16,
  parameter int DECIMAL_PT = 8,
  parameter int SIZE_FFT   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  sine_wave_in,
  twiddle_sequencer_if.slave                  bus
);
  localparam int LOG2_N = $clog2(SIZE_FFT);
  localparam int KW     = LOG2_N - 1;
  localparam int SW     = (LOG2_N > 1) ? $clog2(LOG2_N) : 1;

  if (SIZE_FFT < 4 || (SIZE_FFT & (SIZE_FFT - 1)) != 0 ||
      DECIMAL_PT >= BIT_WIDTH || BIT_WIDTH > 31) begin : g_bad_params
    $error("twiddle_sequencer: unsupported parameter set");
  end

  seq_state_t                  state;
  logic [SW-1:0]               stage_r;
  logic                        inv_r;
  logic                        cfg_rdy_r;

  logic [SW-1:0]               stage_in;
  logic [KW-1:0]               calc_k;
  logic [SW-1:0]               calc_s;
  logic [LOG2_N-1:0]           idx_sin;
  logic [LOG2_N-1:0]           idx_cos;
  logic                        inv_p0;
  logic signed [BIT_WIDTH-1:0] sin_p0;
  logic signed [BIT_WIDTH-1:0] re_p0;
  logic signed [BIT_WIDTH-1:0] im_p0;
  logic                        last_p0;

  logic                        vld_p1;
  logic signed [BIT_WIDTH-1:0] re_p1;
  logic signed [BIT_WIDTH-1:0] im_p1;
  logic [KW-1:0]               k_p1;
  logic                        last_p1;

  logic                        fire_cfg;
  logic                        fire_tw;

  assign fire_cfg = bus.cfg_val & cfg_rdy_r;
  assign fire_tw  = vld_p1 & bus.tw_rdy;

  // Out-of-range stages fold onto the final stage.
  assign stage_in = (int'(bus.cfg_stage) >= LOG2_N) ? SW'(LOG2_N - 1) : bus.cfg_stage;

  twiddle_index_calc #(
    .SIZE_FFT (SIZE_FFT)
  ) u_index_calc (
    .k       (calc_k),
    .s       (calc_s),
    .idx_sin (idx_sin),
    .idx_cos (idx_cos)
  );

  // ---- p0: next beat, addressed from the incoming config in IDLE and from
  //      the stored config plus the current index while running
  always_comb begin
    if (state == ST_IDLE) begin
      calc_k = '0;
      calc_s = stage_in;
      inv_p0 = bus.cfg_inverse;
    end else begin
      calc_k = k_p1 + KW'(1);
      calc_s = stage_r;
      inv_p0 = inv_r;
    end
    sin_p0  = sine_wave_in[idx_sin];
    re_p0   = sine_wave_in[idx_cos];
    im_p0   = inv_p0 ? sin_p0 : BIT_WIDTH'(sat_neg(32'(sin_p0), BIT_WIDTH));
    last_p0 = &calc_k;
  end

  // ---- p1: control FSM and registered output beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      stage_r   <= '0;
      inv_r     <= 1'b0;
      cfg_rdy_r <= 1'b1;
      vld_p1    <= 1'b0;
      re_p1     <= '0;
      im_p1     <= '0;
      k_p1      <= '0;
      last_p1   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire_cfg) begin
            state     <= ST_RUN;
            stage_r   <= stage_in;
            inv_r     <= bus.cfg_inverse;
            cfg_rdy_r <= 1'b0;
            vld_p1    <= 1'b1;
            re_p1     <= re_p0;
            im_p1     <= im_p0;
            k_p1      <= calc_k;
            last_p1   <= last_p0;
          end
        end
        ST_RUN: begin
          if (fire_tw) begin
            if (last_p1) begin
              state     <= ST_IDLE;
              cfg_rdy_r <= 1'b1;
              vld_p1    <= 1'b0;
            end else begin
              re_p1   <= re_p0;
              im_p1   <= im_p0;
              k_p1    <= calc_k;
              last_p1 <= last_p0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cfg_rdy  = cfg_rdy_r;
  assign bus.tw_val   = vld_p1;
  assign bus.tw_real  = re_p1;
  assign bus.tw_imag  = im_p1;
  assign bus.tw_index = k_p1;
  assign bus.tw_last  = last_p1;

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Scoreboard bench for twiddle_sequencer (N=8, W=16).
module tb_twiddle_sequencer;
  import twiddle_sequencer_pkg::*;

  localparam int W    = 16;
  localparam int N    = 8;
  localparam int LOGN = 3;

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
  } beat_t;

  logic                 clk;
  logic                 rst;
  logic [N-1:0][W-1:0]  sine;
  beat_t                exp_q[$];
  int                   checks;
  int                   errors;
  int                   rdy_mode;
  int                   stall_cnt;

  twiddle_sequencer_if #(.BIT_WIDTH(W), .SIZE_FFT(N)) bus ();

  twiddle_sequencer #(
    .BIT_WIDTH  (W),
    .DECIMAL_PT (8),
    .SIZE_FFT   (N)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .sine_wave_in (sine),
    .bus          (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int tabval(input int i);
    twiddle_t v;
    v = sine[i];
    return int'(v);
  endfunction

  task automatic load_default_table();
    twiddle_t vals[N];
    vals = '{16'sd0, 16'sd181, 16'sd256, 16'sd181, 16'sd0, -16'sd181, -16'sd256, -16'sd181};
    for (int i = 0; i < N; i++) sine[i] = vals[i];
  endtask

  // Reference: stage s uses W_{2^(s+1)}^m with m = k mod 2^s, i.e. angle
  // 2*pi*m/2^(s+1), which is table position m * N/2^(s+1).
  task automatic push_run(input int stage, input int inv);
    int s;
    beat_t b;
    s = (stage > LOGN - 1) ? LOGN - 1 : stage;
    for (int k = 0; k < N / 2; k++) begin
      int m;
      int pos;
      int sv;
      m     = k % (2 ** s);
      pos   = m * (N / (2 ** (s + 1)));
      sv    = tabval(pos);
      b.re  = tabval((pos + N / 4) % N);
      b.im  = inv ? sv : ((-sv > 32767) ? 32767 : -sv);
      b.idx = k;
      b.last = (k == N / 2 - 1) ? 1 : 0;
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the first beat appears.
  task automatic start_cfg(input int stage, input int inv);
    int n;
    n = 0;
    while (!bus.cfg_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cfg_rdy_before_cfg", int'(bus.cfg_rdy), 1);
    bus.cfg_val     = 1'b1;
    bus.cfg_stage   = 2'(stage);
    bus.cfg_inverse = inv[0];
    push_run(stage, inv);
    @(posedge clk); #1;
    bus.cfg_val = 1'b0;
    @(negedge clk);
    chk("latency_tw_val", int'(bus.tw_val), 1);
    chk("run_cfg_rdy", int'(bus.cfg_rdy), 0);
    @(posedge clk); #1;
  endtask

  task automatic finish_run(input int pulse);
    int n;
    if (pulse != 0) begin
      bus.cfg_val     = 1'b1;
      bus.cfg_stage   = 2'd0;
      bus.cfg_inverse = ~bus.cfg_inverse;
      @(posedge clk); #1;
      bus.cfg_val = 1'b0;
    end
    n = 0;
    while (!(exp_q.size() == 0 && bus.cfg_rdy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("run_complete_pending", exp_q.size(), 0);
    chk("bubble_tw_val", int'(bus.tw_val), 0);
  endtask

  task automatic run(input int stage, input int inv, input int pulse);
    start_cfg(stage, inv);
    finish_run(pulse);
  endtask

  // Consumer ready generator, updated shortly after each edge.
  initial begin
    bus.tw_rdy = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: bus.tw_rdy = ($urandom_range(0, 3) != 0);
        1: bus.tw_rdy = 1'b1;
        2: bus.tw_rdy = 1'b0;
        default: begin
          if (bus.tw_val && bus.tw_index == 2'd1 && stall_cnt < 3) begin
            bus.tw_rdy = 1'b0;
            stall_cnt++;
          end else begin
            bus.tw_rdy = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: pops and compares each accepted beat; checks stalled beats hold.
  initial begin
    bit    held;
    beat_t h;
    beat_t e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_val", int'(bus.tw_val), 1);
          chk("hold_real", int'(bus.tw_real), h.re);
          chk("hold_imag", int'(bus.tw_imag), h.im);
          chk("hold_index", int'(bus.tw_index), h.idx);
        end
        if (bus.tw_val && bus.tw_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual index=%0d required no beat at %0t",
                     bus.tw_index, $time);
          end else begin
            e = exp_q.pop_front();
            chk("tw_real", int'(bus.tw_real), e.re);
            chk("tw_imag", int'(bus.tw_imag), e.im);
            chk("tw_index", int'(bus.tw_index), e.idx);
            chk("tw_last", int'(bus.tw_last), e.last);
          end
          held = 1'b0;
        end else if (bus.tw_val) begin
          held  = 1'b1;
          h.re  = int'(bus.tw_real);
          h.im  = int'(bus.tw_imag);
          h.idx = int'(bus.tw_index);
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    checks          = 0;
    errors          = 0;
    rdy_mode        = 1;
    stall_cnt       = 0;
    rst             = 1'b1;
    bus.cfg_val     = 1'b0;
    bus.cfg_stage   = 2'd0;
    bus.cfg_inverse = 1'b0;
    load_default_table();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tw_val", int'(bus.tw_val), 0);
    chk("reset_cfg_rdy", int'(bus.cfg_rdy), 1);
    chk("reset_tw_real", int'(bus.tw_real), 0);
    chk("reset_tw_imag", int'(bus.tw_imag), 0);
    chk("reset_tw_index", int'(bus.tw_index), 0);
    chk("reset_tw_last", int'(bus.tw_last), 0);
    @(posedge clk); #1;

    // Directed stages, forward and inverse
    run(0, 0, 0);
    run(1, 0, 0);
    run(2, 0, 0);
    run(2, 1, 0);

    // Backpressure on k=1 with an ignored mid-run config pulse
    stall_cnt = 0;
    rdy_mode  = 3;
    run(2, 0, 1);
    chk("stall_cycles", stall_cnt, 3);

    // Saturating negation, then stage clamp
    rdy_mode = 1;
    sine[0]  = 16'h8000;
    run(0, 0, 0);
    load_default_table();
    run(3, 0, 0);

    // Reset mid-run at k=2
    start_cfg(2, 0);
    n = 0;
    while (!(bus.tw_val && bus.tw_index == 2'd2) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reset_reach_k2", int'(bus.tw_index), 2);
    rst      = 1'b1;
    rdy_mode = 2;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tw_val", int'(bus.tw_val), 0);
    chk("abort_cfg_rdy", int'(bus.cfg_rdy), 1);
    chk("abort_tw_index", int'(bus.tw_index), 0);
    chk("abort_tw_last", int'(bus.tw_last), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rdy_mode = 1;
    run(0, 0, 0);

    // Randomized runs with random backpressure and tables
    rdy_mode = 0;
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < N; i++) begin
          case ($urandom_range(0, 3))
            0: sine[i] = 16'h8000;
            1: sine[i] = 16'h7fff;
            default: sine[i] = 16'($urandom);
          endcase
        end
      end
      run(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
